// File: rtl/mme_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
//   state_e : sequencer states (IDLE/LOAD/REQ/STEP/OUT/DONE)
//   op_e    : operation of the current Montgomery task (square or multiply)
//   WR_*    : bit positions inside the core's wr_ena bus
//   LD_*    : host ld_sel codes (code 3 is ignored)
package mme_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_STEP,
    ST_OUT,
    ST_DONE
  } state_e;

  typedef enum logic {
    OP_SQR,
    OP_MUL
  } op_e;

  localparam int unsigned WR_X = 0;
  localparam int unsigned WR_Y = 1;
  localparam int unsigned WR_M = 2;

  localparam logic [1:0] LD_BASE = 2'd0;
  localparam logic [1:0] LD_ACC  = 2'd1;
  localparam logic [1:0] LD_MOD  = 2'd2;

endpackage

// File: rtl/mme_word_buf.sv
// N x K word RAM, one write port and one registered read port (BRAM style).
//   clk   : clock
//   we    : write enable, waddr/wdata : write word index / data
//   raddr : read word index; rdata is valid one cycle after raddr
module mme_word_buf #(
  parameter  int unsigned K  = 128,
  parameter  int unsigned N  = 32,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [K-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [K-1:0]  rdata
);

  logic [K-1:0] mem [N];
  logic [K-1:0] rdata_q;

  // No reset: contents and read register are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mme_iddmm_ctrl.sv
// Left-to-right square-and-multiply sequencer around one mmp_iddmm_sp
// Montgomery multiplier core. Computes A = B^E in the Montgomery domain,
// processing every exponent bit (constant time).
//   Host side : ld_we/ld_sel/ld_addr/ld_data load base, accumulator init or
//               modulus (modulus is forwarded to the core); start/exp launch
//               a run; busy, res_val/res_data (LSW first), done, err (sticky
//               word-count error, cleared by the next accepted start).
//   Core side : core_wr_ena/addr/x/y/m operand write port, core_task_req,
//               core_task_end, core_task_grant/core_task_res result stream.
module mme_iddmm_ctrl
  import mme_pkg::*;
#(
  parameter  int unsigned K      = 128,
  parameter  int unsigned N      = 32,
  parameter  int unsigned E_BITS = 4096,
  localparam int unsigned AW     = $clog2(N),
  localparam int unsigned BW     = $clog2(E_BITS),
  localparam int unsigned CW     = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_we,
  input  logic [1:0]        ld_sel,
  input  logic [AW-1:0]     ld_addr,
  input  logic [K-1:0]      ld_data,
  input  logic              start,
  input  logic [E_BITS-1:0] exp,
  output logic              busy,
  output logic              res_val,
  output logic [K-1:0]      res_data,
  output logic              done,
  output logic              err,
  output logic [2:0]        core_wr_ena,
  output logic [AW-1:0]     core_wr_addr,
  output logic [K-1:0]      core_wr_x,
  output logic [K-1:0]      core_wr_y,
  output logic [K-1:0]      core_wr_m,
  output logic              core_task_req,
  input  logic              core_task_end,
  input  logic              core_task_grant,
  input  logic [K-1:0]      core_task_res
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [E_BITS-1:0] exp_q, exp_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              res_val_q, res_val_d;
  logic              done_q, done_d;
  logic [2:0]        wr_ena_q, wr_ena_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [K-1:0]      wr_m_q, wr_m_d;

  logic              grant_take;
  logic              host_wr;
  logic              acc_we, base_we;
  logic [AW-1:0]     acc_waddr;
  logic [K-1:0]      acc_wdata;
  logic [K-1:0]      acc_rdata, base_rdata;

  // ---------------------------------------------------------------- buffers
  assign host_wr    = (state_q == ST_IDLE) && ld_we;
  // Result words beyond N are dropped rather than wrapping into the buffer.
  assign grant_take = (state_q == ST_REQ) && core_task_grant && (wcnt_q < CW'(N));

  always_comb begin
    acc_we    = grant_take || (host_wr && (ld_sel == LD_ACC));
    acc_waddr = grant_take ? wcnt_q[AW-1:0] : ld_addr;
    acc_wdata = grant_take ? core_task_res : ld_data;
    base_we   = host_wr && (ld_sel == LD_BASE);
  end

  mme_word_buf #(.K(K), .N(N)) u_acc_buf (
    .clk   (clk),
    .we    (acc_we),
    .waddr (acc_waddr),
    .wdata (acc_wdata),
    .raddr (cnt_q),
    .rdata (acc_rdata)
  );

  mme_word_buf #(.K(K), .N(N)) u_base_buf (
    .clk   (clk),
    .we    (base_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (cnt_q),
    .rdata (base_rdata)
  );

  // --------------------------------------------------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_SQR;
      exp_q     <= '0;
      bit_q     <= BW'(E_BITS - 1);
      cnt_q     <= '0;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      res_val_q <= 1'b0;
      done_q    <= 1'b0;
      wr_ena_q  <= '0;
      wr_addr_q <= '0;
      wr_m_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      exp_q     <= exp_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      req_q     <= req_d;
      res_val_q <= res_val_d;
      done_q    <= done_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_m_q    <= wr_m_d;
    end
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    exp_d   = exp_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          op_d    = OP_SQR;
          exp_d   = exp;
          bit_d   = BW'(E_BITS - 1);
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (cnt_q == AW'(N - 1)) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          wcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REQ: begin
        if (grant_take) begin
          wcnt_d = wcnt_q + 1'b1;
        end
        // wcnt_d already includes a grant coincident with task_end.
        if (req_q && core_task_end) begin
          state_d = ST_STEP;
          if (wcnt_d != CW'(N)) begin
            err_d = 1'b1;
          end
        end
      end
      ST_STEP: begin
        if ((op_q == OP_SQR) && exp_q[bit_q]) begin
          op_d    = OP_MUL;
          state_d = ST_LOAD;
        end else if (bit_q == '0) begin
          state_d = ST_OUT;
        end else begin
          bit_d   = bit_q - 1'b1;
          op_d    = OP_SQR;
          state_d = ST_LOAD;
        end
      end
      ST_OUT: begin
        if (cnt_q == AW'(N - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Registered controls lag the state by one cycle, which lines them up with
  // the registered buffer read addressed by cnt_q.
  always_comb begin
    busy_d    = busy_q;
    req_d     = 1'b0;
    res_val_d = 1'b0;
    done_d    = 1'b0;
    wr_ena_d  = '0;
    wr_addr_d = '0;
    wr_m_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
        end
        if (ld_we && (ld_sel == LD_MOD)) begin
          wr_ena_d[WR_M] = 1'b1;
          wr_addr_d      = ld_addr;
          wr_m_d         = ld_data;
        end
      end
      ST_LOAD: begin
        wr_ena_d[WR_X] = 1'b1;
        wr_ena_d[WR_Y] = 1'b1;
        wr_addr_d      = cnt_q;
      end
      ST_REQ: begin
        req_d = !(req_q && core_task_end);
      end
      ST_OUT: begin
        res_val_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign busy          = busy_q;
  assign err           = err_q;
  assign done          = done_q;
  assign res_val       = res_val_q;
  assign res_data      = res_val_q ? acc_rdata : '0;
  assign core_task_req = req_q;
  assign core_wr_ena   = wr_ena_q;
  assign core_wr_addr  = wr_addr_q;
  assign core_wr_m     = wr_m_q;
  assign core_wr_x     = wr_ena_q[WR_X] ? acc_rdata : '0;
  assign core_wr_y     = wr_ena_q[WR_Y] ? ((op_q == OP_MUL) ? base_rdata : acc_rdata) : '0;

endmodule

// File: doc/mme_iddmm_ctrl.md
Name: mme_iddmm_ctrl

Overview:
- Modular-exponentiation sequencer that drives one mmp_iddmm_sp Montgomery multiplier core.
- Computes A = B^E in the Montgomery domain using left-to-right square-and-multiply.
- Holds the accumulator and base in internal word buffers.
- Streams operands into the core's write port, issues task_req and captures the result words back into the accumulator.
- Sits between the Paillier/RSA host logic and the multiplier core; the core's m1 input is fed directly by the host.

Parameters:
- K, 128, word width in bits (must equal the core's K).
- N, 32, words per big number (must equal the core's N).
- E_BITS, 4096, exponent width; all bits are processed, no leading-zero skip (constant time).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ld_we  in  1  host word write; accepted only in IDLE.
- ld_sel  in  2  write target: 0 = base B, 1 = accumulator init (R mod m), 2 = modulus m (forwarded to core), 3 = ignored.
- ld_addr  in  $clog2(N)  word index, 0 = LSW.
- ld_data  in  K  word data.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- exp  in  E_BITS  exponent, latched on an accepted start.
- busy  out  1  high from start acceptance until done.
- res_val  out  1  result word strobe.
- res_data  out  K  result word, LSW first.
- done  out  1  1-cycle pulse on the cycle after the last res_val.
- err  out  1  sticky word-count error; cleared by the next accepted start.
- core_wr_ena  out  3  to core wr_ena: bit0 = x, bit1 = y, bit2 = m.
- core_wr_addr  out  $clog2(N)  to core wr_addr.
- core_wr_x / core_wr_y / core_wr_m  out  K each  to core wr_x / wr_y / wr_m.
- core_task_req  out  1  to core task_req.
- core_task_end  in  1  from core task_end.
- core_task_grant  in  1  from core task_grant (result word valid).
- core_task_res  in  K  from core task_res.

Behaviour:
- Reset: all outputs 0, state IDLE, bit index E_BITS-1, word counters 0. Reset mid-operation aborts immediately: core_task_req drops and buffer contents are don't-care.
- IDLE, ld_we, ld_sel=0/1: registered write into base_buf or acc_buf.
- IDLE, ld_we, ld_sel=2: same cycle registered drive of core_wr_ena=3'b100, core_wr_addr=ld_addr, core_wr_m=ld_data.
- Accepted start: latch exp, set bit index i=E_BITS-1, op=SQR, clear err, assert busy, go to LOAD. start or ld_we while busy is ignored.
- LOAD (N cycles): core_wr_ena=3'b011, core_wr_addr counts 0..N-1.
  - core_wr_x = acc_buf[addr].
  - core_wr_y = acc_buf[addr] for SQR, base_buf[addr] for MUL.
  - Buffer reads are registered; the address/data pipeline is aligned so ena, addr and data change together.
- REQ: core_task_req rises the cycle after the last LOAD word and stays high until core_task_end is sampled high; it falls the following cycle.
  - Each cycle core_task_grant=1: acc_buf[wcnt] <= core_task_res, wcnt++.
  - A grant arriving in the same cycle as task_end is captured.
  - Grants beyond N words are dropped.
  - At task_end, if captured words != N, set err and continue.
- STEP:
  - op=SQR and exp[i]=1: op=MUL, go to LOAD.
  - Otherwise: if i==0, go to OUT; else i--, op=SQR, go to LOAD.
- OUT (N cycles): res_val=1, res_data=acc_buf[0..N-1], LSW first.
- DONE: done=1 for one cycle, busy drops, return to IDLE. acc_buf keeps the result until overwritten.
- Task count = E_BITS + popcount(exp). exp=0 returns the accumulator init value after E_BITS squarings (Montgomery one is a fixed point of squaring).

Decomposition:
- Shared package mme_pkg holds:
  - state encoding IDLE/LOAD/REQ/STEP/OUT/DONE;
  - op encoding SQR/MUL;
  - wr_ena bit positions WR_X=0, WR_Y=1, WR_M=2;
  - ld_sel codes.
- One sub-module, mme_word_buf: N×K, 1 write / 1 registered-read word RAM. It is instantiated twice (acc, base) and maps to BRAM.

Test Plan:
- K=8, N=2, m=0xFFF1, R mod m=0x000F, exp=0, E_BITS=4 -> 4 tasks, res words 0x0F, 0x00, done pulse, err=0.
- Same setup, base_mont=0x1234, exp=4'b0001 -> 5 tasks, result 0x1234 (words 0x34, 0x12).
- exp=4'b0011 with behavioural core model -> 6 core_task_req rising edges in order SQR, SQR, SQR, MUL, SQR, MUL; result equals golden Montgomery B^3.
- Model returns only 1 grant word before task_end -> err=1, sequence completes, done pulses; next start clears err.
- rst asserted during REQ of the third task -> core_task_req, busy, res_val fall asynchronously; a new load+start, exp=1, gives the correct result.
- start and ld_we pulsed while busy -> ignored; buffers, core_wr_ena and the task count are unchanged.
